// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM state type,
// iteration count and small op-decode helpers.
package mdu_pkg;

  localparam int unsigned ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bus between the pipeline and the multiply/divide unit,
// including the MTHI/MTLO write strobes and the HI/LO read-out.
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_negate.sv
// Conditional two's-complement of a WIDTH-bit value; used for operand magnitudes
// and for fixing the sign of results.
module mdu_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] res_o
);

  always_comb begin
    res_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers: shift-add multiply and
// restoring divide on one shared 64-bit shift register, one result bit per cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned ITER = mdu_pkg::ITER
) (
  input logic           clk,
  input logic           reset,
  mult_div_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(ITER);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  op_e            op_q, op_d;
  logic [63:0]    acc_q, acc_d;
  logic [31:0]    opnd_q, opnd_d;
  logic [31:0]    a_raw_q, a_raw_d;
  logic           b_zero_q, b_zero_d;
  logic           neg_res_q, neg_res_d;
  logic           neg_rem_q, neg_rem_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  op_e            op_in;
  logic           sgn_in;
  logic [31:0]    mag_a, mag_b;
  logic [32:0]    mul_sum;
  logic [63:0]    mul_next, div_next, acc_step;
  logic           div_ge;
  logic [31:0]    div_sub;
  logic [63:0]    fix_in, fix_out;
  logic [31:0]    rem_fix;

  assign op_in  = op_e'(bus.op);
  assign sgn_in = op_is_signed(op_in);

  mdu_negate #(.WIDTH(32)) u_mag_a (
    .neg_i (sgn_in & bus.a[31]),
    .val_i (bus.a),
    .res_o (mag_a)
  );

  mdu_negate #(.WIDTH(32)) u_mag_b (
    .neg_i (sgn_in & bus.b[31]),
    .val_i (bus.b),
    .res_o (mag_b)
  );

  // One iteration of either algorithm; acc holds {partial, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
    div_ge   = (acc_q[63:31] >= {1'b0, opnd_q});
    div_sub  = acc_q[62:31] - opnd_q;
    div_next = div_ge ? {div_sub, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
    acc_step = op_is_div(op_q) ? div_next : mul_next;
    fix_in   = op_is_div(op_q) ? {32'h0, acc_step[31:0]} : acc_step;
  end

  mdu_negate #(.WIDTH(64)) u_fix_res (
    .neg_i (neg_res_q),
    .val_i (fix_in),
    .res_o (fix_out)
  );

  mdu_negate #(.WIDTH(32)) u_fix_rem (
    .neg_i (neg_rem_q),
    .val_i (acc_step[63:32]),
    .res_o (rem_fix)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    b_zero_d  = b_zero_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    // busy/done are registered from the state, so they trail it by one cycle.
    busy_d    = (state_q == ST_RUN);
    done_d    = (state_q == ST_DONE);

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          op_d      = op_in;
          a_raw_d   = bus.a;
          b_zero_d  = (bus.b == '0);
          neg_res_d = sgn_in & (bus.a[31] ^ bus.b[31]);
          neg_rem_d = sgn_in & bus.a[31];
          if (op_is_div(op_in)) begin
            acc_d  = {32'h0, mag_a};
            opnd_d = mag_b;
          end else begin
            acc_d  = {32'h0, mag_b};
            opnd_d = mag_a;
          end
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = ST_DONE;
          if (op_is_div(op_q)) begin
            if (b_zero_q) begin
              hi_d = a_raw_q;
              lo_d = '1;
            end else begin
              hi_d = rem_fix;
              lo_d = fix_out[31:0];
            end
          end else begin
            hi_d = fix_out[63:32];
            lo_d = fix_out[31:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MULT;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      b_zero_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      b_zero_q  <= b_zero_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, signed/unsigned results,
// divide corner cases, MTHI/MTLO writes, ignored requests and mid-run reset.
module tb_mult_div_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mult_div_unit_if bus ();

  mult_div_unit #(.ITER(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
    lat    = -1;
    busy_n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks += 4;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 00000000", bus.hi); end
    if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 00000000", bus.lo); end
  endtask

  task automatic test_mthi_mtlo();
    bus.hi_we = 1'b1; bus.wdata = 32'h1234_5678;
    step();
    bus.hi_we = 1'b0;
    checks += 2;
    if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi got %h want 12345678", bus.hi); end
    if (bus.lo !== 32'h0) begin errors++; $display("FAIL mthi_lo_untouched got %h want 00000000", bus.lo); end
    bus.lo_we = 1'b1; bus.wdata = 32'h9ABC_DEF0;
    step();
    bus.lo_we = 1'b0;
    checks += 2;
    if (bus.lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo got %h want 9abcdef0", bus.lo); end
    if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi_untouched got %h want 12345678", bus.hi); end
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0000_0055;
    step();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    checks += 2;
    if (bus.hi !== 32'h55) begin errors++; $display("FAIL mthi_both got %h want 00000055", bus.hi); end
    if (bus.lo !== 32'h55) begin errors++; $display("FAIL mtlo_both got %h want 00000055", bus.lo); end
    // start together with write strobes: the writes must not land
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hAAAA_AAAA;
    step();
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    checks += 2;
    if (bus.hi !== 32'h55) begin errors++; $display("FAIL start_wins_hi got %h want 00000055", bus.hi); end
    if (bus.lo !== 32'h55) begin errors++; $display("FAIL start_wins_lo got %h want 00000055", bus.lo); end
    for (int i = 0; i < 40 && !bus.done; i++) step();
    checks += 2;
    if (bus.hi !== 32'h0) begin errors++; $display("FAIL start_wins_res_hi got %h want 00000000", bus.hi); end
    if (bus.lo !== 32'd6) begin errors++; $display("FAIL start_wins_res_lo got %h want 00000006", bus.lo); end
  endtask

  task automatic test_mult();
    int lat, bn;
    run_op(2'b00, 32'hFFFF_FFFF, 32'd2, lat, bn);
    checks += 4;
    if (lat !== 33) begin errors++; $display("FAIL mult_latency got %0d want 33", lat); end
    if (bn !== 32) begin errors++; $display("FAIL mult_busy_cycles got %0d want 32", bn); end
    if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", bus.hi); end
    if (bus.lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo got %h want fffffffe", bus.lo); end
    step();
    checks += 3;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b want 0", bus.done); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_busy_after got %b want 0", bus.busy); end
    if (bus.lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_hold_lo got %h want fffffffe", bus.lo); end
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, lat, bn);
    checks += 2;
    if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg15_hi got %h want ffffffff", bus.hi); end
    if (bus.lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_neg15_lo got %h want fffffff1", bus.lo); end
  endtask

  task automatic test_multu();
    int lat, bn;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bn);
    checks += 3;
    if (lat !== 33) begin errors++; $display("FAIL multu_latency got %0d want 33", lat); end
    if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", bus.hi); end
    if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", bus.lo); end
  endtask

  task automatic test_div();
    int lat, bn;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bn);
    checks += 2;
    if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_q got %h want fffffffd", bus.lo); end
    if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_m7_r got %h want ffffffff", bus.hi); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn);
    checks += 3;
    if (lat !== 33) begin errors++; $display("FAIL div_ovf_latency got %0d want 33", lat); end
    if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_q got %h want 80000000", bus.lo); end
    if (bus.hi !== 32'h0) begin errors++; $display("FAIL div_ovf_r got %h want 00000000", bus.hi); end
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, lat, bn);
    checks += 2;
    if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2_q got %h want fffffffd", bus.lo); end
    if (bus.hi !== 32'd1) begin errors++; $display("FAIL div_7_m2_r got %h want 00000001", bus.hi); end
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, lat, bn);
    checks += 2;
    if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_zero_q got %h want ffffffff", bus.lo); end
    if (bus.hi !== 32'hFFFF_FFF9) begin errors++; $display("FAIL div_zero_r got %h want fffffff9", bus.hi); end
  endtask

  task automatic test_divu();
    int lat, bn;
    run_op(2'b11, 32'd100, 32'd0, lat, bn);
    checks += 3;
    if (lat !== 33) begin errors++; $display("FAIL divu_zero_latency got %0d want 33", lat); end
    if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero_q got %h want ffffffff", bus.lo); end
    if (bus.hi !== 32'h0000_0064) begin errors++; $display("FAIL divu_zero_r got %h want 00000064", bus.hi); end
    run_op(2'b11, 32'd100, 32'd7, lat, bn);
    checks += 2;
    if (bus.lo !== 32'd14) begin errors++; $display("FAIL divu_100_7_q got %h want 0000000e", bus.lo); end
    if (bus.hi !== 32'd2) begin errors++; $display("FAIL divu_100_7_r got %h want 00000002", bus.hi); end
  endtask

  task automatic test_ignore_in_run();
    int lat;
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd5;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd9; bus.b = 32'd3;
    bus.hi_we = 1'b1; bus.lo_we = 1'b0; bus.wdata = 32'hDEAD_BEEF;
    step();
    bus.start = 1'b0; bus.hi_we = 1'b0;
    lat = -1;
    for (int i = 6; i <= 40; i++) begin
      step();
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    checks += 3;
    if (lat !== 33) begin errors++; $display("FAIL ignore_latency got %0d want 33", lat); end
    if (bus.lo !== 32'd15) begin errors++; $display("FAIL ignore_lo got %h want 0000000f", bus.lo); end
    if (bus.hi !== 32'd0) begin errors++; $display("FAIL ignore_hi got %h want 00000000", bus.hi); end
  endtask

  task automatic test_reset_mid_run();
    int lat, bn;
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd5;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks += 4;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", bus.done); end
    if (bus.hi !== 32'h0) begin errors++; $display("FAIL midreset_hi got %h want 00000000", bus.hi); end
    if (bus.lo !== 32'h0) begin errors++; $display("FAIL midreset_lo got %h want 00000000", bus.lo); end
    for (int i = 0; i < 3; i++) step();
    checks += 1;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_no_done got %b want 0", bus.done); end
    run_op(2'b11, 32'd9, 32'd3, lat, bn);
    checks += 3;
    if (lat !== 33) begin errors++; $display("FAIL after_reset_latency got %0d want 33", lat); end
    if (bus.lo !== 32'd3) begin errors++; $display("FAIL after_reset_q got %h want 00000003", bus.lo); end
    if (bus.hi !== 32'd0) begin errors++; $display("FAIL after_reset_r got %h want 00000000", bus.hi); end
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, lat, bn);
    checks += 2;
    if (bus.hi !== 32'd1) begin errors++; $display("FAIL b2b_first_hi got %h want 00000001", bus.hi); end
    if (bus.lo !== 32'd0) begin errors++; $display("FAIL b2b_first_lo got %h want 00000000", bus.lo); end
    run_op(2'b11, 32'hFFFF_FFFF, 32'h0001_0000, lat, bn);
    checks += 3;
    if (lat !== 33) begin errors++; $display("FAIL b2b_second_latency got %0d want 33", lat); end
    if (bus.lo !== 32'h0000_FFFF) begin errors++; $display("FAIL b2b_second_q got %h want 0000ffff", bus.lo); end
    if (bus.hi !== 32'h0000_FFFF) begin errors++; $display("FAIL b2b_second_r got %h want 0000ffff", bus.hi); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_multu();
    test_div();
    test_divu();
    test_ignore_in_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter ITER, default 32, number of RUN iterations (one result bit per cycle); SHALL be fixed at 32 for this core.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin the operation selected by op; sampled on the clock edge.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  rs operand (multiplicand / dividend).
REQ-007 b  input  32  rt operand (multiplier / divisor).
REQ-008 hi_we, lo_we  input  1 each  MTHI / MTLO write strobes.
REQ-009 wdata  input  32  data for MTHI / MTLO.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse when hi/lo hold a new result.
REQ-012 hi, lo  output  32 each  HI/LO registers; feed the writeback 32-bit select for MFHI/MFLO.

Function
REQ-013 FSM states: IDLE, RUN, DONE; DONE SHALL last exactly one cycle, then go to IDLE.
REQ-014 start=1 in IDLE or DONE SHALL latch a, b, op; clear the iteration counter; enter RUN.
REQ-015 start while in RUN SHALL be ignored; no operand or op change.
REQ-016 RUN SHALL last exactly ITER cycles; counter 0..31; the edge at count 31 SHALL write hi/lo and enter DONE.
REQ-017 Latency: start sampled at edge 0 -> hi/lo valid and done=1 after edge 33; busy=1 after edges 1..32 only.
REQ-018 Multiply: shift-add on magnitudes, 64-bit product; hi = product[63:32], lo = product[31:0].
REQ-019 Signed ops (MULT, DIV): operands SHALL be converted to magnitude at start; result sign-fixed at the final edge.
REQ-020 MULT product SHALL be negated iff a[31]^b[31].
REQ-021 Divide: restoring, one quotient bit per cycle; lo = quotient, hi = remainder.
REQ-022 DIV quotient negated iff a[31]^b[31]; remainder takes the sign of a (truncation toward zero).
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0; no trap.
REQ-024 Divide by zero (DIV or DIVU): full ITER latency; lo=0xFFFFFFFF, hi=a (raw operand).
REQ-025 hi_we / lo_we in IDLE or DONE SHALL write wdata to hi / lo on that edge; both may assert together.
REQ-026 hi_we / lo_we while in RUN SHALL be ignored.
REQ-027 start together with hi_we/lo_we: start wins; the writes are discarded.
REQ-028 hi/lo SHALL hold their value outside result and MTHI/MTLO write edges.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE; busy=0, done=0, hi=0, lo=0, counter=0, from any state including mid-RUN.
REQ-030 reset SHALL take priority over start, hi_we and lo_we.

Structure
REQ-031 Shared package mdu_pkg SHALL hold op encodings, the FSM state type, and ITER.
REQ-032 A single sub-module, mdu_negate (width-parameterised conditional two's-complement), SHALL serve both operand-magnitude and result sign-fix paths.
REQ-033 The datapath SHALL use one 64-bit shift register shared by multiply and divide; no combinational array multiplier or divider.

Verification
REQ-034 MULT a=0xFFFFFFFF, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, done exactly 33 cycles after start.
REQ-035 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064 after 33 cycles.
REQ-038 Start MULTU 3x5; second start (DIVU 9/3) plus hi_we=1 at RUN cycle 5 -> both ignored; lo=15, hi=0.
REQ-039 Reset at RUN cycle 10 -> next cycle busy=0, done=0, hi=lo=0; a subsequent start completes normally.
